imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 128 ++++++++++++
 tb/tb_imm_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that inserts a signed immediate
// into a RISC-V style instruction word in I, S, B or J format.
// Optional feature: define IMM_RANGE_CHECK_EN to enable immediate range
// checking (out_err flag and saturating err_count). Without it out_err and
// err_count stay 0; datapath and latency are identical.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_immsrc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_t;

  logic        s1_valid;
  logic [31:0] s1_instr;
  logic [31:0] s1_imm;
  fmt_t        s1_fmt;

  logic        s2_en;
  logic        s1_en;
  logic        accept;
  logic [31:0] asm_word;
  logic        asm_err;

  // Output stage (out_valid doubles as the S2 valid bit) loads when empty or draining
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en && !rst;
  assign accept   = in_valid && in_ready;

  // Assemble the word: start from the base instruction, overwrite the immediate field
  always_comb begin
    asm_word = s1_instr;
    case (s1_fmt)
      FMT_I: asm_word[31:20] = s1_imm[11:0];
      FMT_S: begin
        asm_word[31:25] = s1_imm[11:5];
        asm_word[11:7]  = s1_imm[4:0];
      end
      FMT_B: begin
        asm_word[31]    = s1_imm[12];
        asm_word[30:25] = s1_imm[10:5];
        asm_word[11:8]  = s1_imm[4:1];
        asm_word[7]     = s1_imm[11];
      end
      FMT_J: begin
        asm_word[31]    = s1_imm[20];
        asm_word[30:21] = s1_imm[10:1];
        asm_word[20]    = s1_imm[11];
        asm_word[19:12] = s1_imm[19:12];
      end
      default: asm_word = s1_instr;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // In range when all bits above the field's sign bit replicate it; B/J also need an even value
  always_comb begin
    asm_err = 1'b0;
    case (s1_fmt)
      FMT_I, FMT_S: asm_err = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      FMT_B:        asm_err = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
      FMT_J:        asm_err = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
      default:      asm_err = 1'b0;
    endcase
  end

  // Saturating count of erroneous items actually handed downstream
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (out_valid && out_ready && out_err && (err_count != '1))
      err_count <= err_count + 8'd1;
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^{s1_imm[31:21], s1_imm[0]};
  assign asm_err       = 1'b0;
  assign err_count     = '0;
`endif

  // Input stage: capture an accepted item, or go empty when its item moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_imm   <= '0;
      s1_fmt   <= FMT_I;
    end else if (s1_en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_instr <= in_instr;
        s1_imm   <= in_imm;
        s1_fmt   <= fmt_t'(in_immsrc);
      end
    end
  end

  // Output stage: register assembled word and flag; held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= asm_word;
        out_err   <= asm_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: scoreboard of expected words/flags
// pushed at accept and popped on each output handshake, plus directed checks.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_imm;
  logic [1:0]  in_immsrc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  logic [32:0] sb[$];        // {err, word}
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_imm    (in_imm),
    .in_immsrc (in_immsrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  // Reference: build the word by concatenation, check range arithmetically
  function automatic logic [32:0] model(input logic [31:0] ins, input logic [31:0] imm,
                                        input logic [1:0] src);
    logic [31:0] w;
    logic        e;
    int          v;
    v = $signed(imm);
    case (src)
      2'd0: begin w = {imm[11:0], ins[19:0]}; e = (v < -2048) || (v > 2047); end
      2'd1: begin w = {imm[11:5], ins[24:12], imm[4:0], ins[6:0]}; e = (v < -2048) || (v > 2047); end
      2'd2: begin
        w = {imm[12], imm[10:5], ins[24:12], imm[4:1], imm[11], ins[6:0]};
        e = (v < -4096) || (v > 4094) || imm[0];
      end
      default: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], ins[11:0]};
        e = (v < -1048576) || (v > 1048574) || imm[0];
      end
    endcase
`ifndef IMM_RANGE_CHECK_EN
    e = 1'b0;
`endif
    return {e, w};
  endfunction

  // Output monitor: every handshake must match the oldest expected item
  always @(negedge clk) begin
    logic [32:0] exp;
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
    end else if (out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got instr=%h err=%b, expected no output", out_instr, out_err);
      end else begin
        exp = sb.pop_front();
        if (out_instr !== exp[31:0] || out_err !== exp[32]) begin
          fails++;
          $display("FAIL scoreboard: got instr=%h err=%b, expected instr=%h err=%b",
                   out_instr, out_err, exp[31:0], exp[32]);
        end
        tests++;
        if (err_count !== exp_cnt[7:0]) begin
          fails++;
          $display("FAIL err_count_track: got %0d, expected %0d", err_count, exp_cnt);
        end
        if (exp[32] && exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // Offer one item; pushes its expectation at the cycle it is accepted
  task automatic send(input logic [31:0] ins, input logic [31:0] imm, input logic [1:0] src);
    int unsigned n = 0;
    bit done = 0;
    in_valid = 1'b1; in_instr = ins; in_imm = imm; in_immsrc = src;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(ins, imm, src));
        done = 1;
      end else if (++n > 50) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (sb.size() != 0 || out_valid) begin
      fails++;
      $display("FAIL drain_timeout: pending=%0d out_valid=%b, expected 0 and 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_err !== 1'b0 ||
        out_instr !== 32'h0 || err_count !== 8'h0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b ov=%b err=%b instr=%h cnt=%0d, expected 0 0 0 0 0",
               in_ready, out_valid, out_err, out_instr, err_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b, expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_i_latency();
    send(32'h0000_0013, 32'hFFFF_FFFF, 2'd0);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL i_latency_early: out_valid=%b, expected 0 one cycle after accept", out_valid);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF0_0013 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL i_format: ov=%b instr=%h err=%b, expected 1 fff00013 0", out_valid, out_instr, out_err);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send(32'h0000_2023, 32'h0000_07FF, 2'd1);
    send(32'h0000_0063, 32'hFFFF_FFFC, 2'd2);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'h7E00_2FA3) begin
      fails++;
      $display("FAIL s_format: ov=%b instr=%h, expected 1 7e002fa3", out_valid, out_instr);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFE00_0EE3) begin
      fails++;
      $display("FAIL b_format_next: ov=%b instr=%h, expected 1 fe000ee3", out_valid, out_instr);
    end
    wait_drain();
  endtask

  task automatic test_j_format();
    send(32'h0000_006F, 32'h0000_0800, 2'd3);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0010_006F || out_err !== 1'b0) begin
      fails++;
      $display("FAIL j_format: ov=%b instr=%h err=%b, expected 1 0010006f 0", out_valid, out_instr, out_err);
    end
    wait_drain();
  endtask

  task automatic test_range();
    logic [7:0] e1, e2;
`ifdef IMM_RANGE_CHECK_EN
    e1 = 8'd1; e2 = 8'd2;
`else
    e1 = 8'd0; e2 = 8'd0;
`endif
    send(32'h0000_0013, 32'h0000_0800, 2'd0);
    wait_drain();
    @(negedge clk);
    tests++;
    if (err_count !== e1) begin
      fails++;
      $display("FAIL range_i_count: got %0d, expected %0d", err_count, e1);
    end
    @(posedge clk); #1;
    send(32'h0000_0063, 32'h0000_0003, 2'd2);
    wait_drain();
    @(negedge clk);
    tests++;
    if (err_count !== e2) begin
      fails++;
      $display("FAIL range_b_count: got %0d, expected %0d", err_count, e2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0013, 32'h0000_0001, 2'd0);
        send(32'h0000_2023, 32'h0000_0002, 2'd1);
        send(32'h0000_006F, 32'h0000_0004, 2'd3);
      end
      begin
        logic [31:0] held;
        int unsigned n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        held = out_instr;
        for (int unsigned i = 0; i < 3; i++) begin
          @(negedge clk);
          tests++;
          if (out_valid !== 1'b1 || out_instr !== held) begin
            fails++;
            $display("FAIL stall_hold: ov=%b instr=%h, expected 1 %h", out_valid, out_instr, held);
          end
          tests++;
          if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_backpressure: in_ready=%b, expected 0", in_ready);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h0000_0800, 2'd0);
    send(32'h0000_0063, 32'h0000_0003, 2'd2);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_in_reset: got %b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_state: ov=%b rdy=%b, expected 0 1", out_valid, in_ready);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (err_count !== 8'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_count: cnt=%0d ov=%b, expected 0 0", err_count, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 40; i++) begin
      logic [31:0] imm;
      imm = $urandom();
      if (i % 2 == 0) imm = {{20{imm[11]}}, imm[11:1], 1'b0};
      send($urandom(), imm, 2'($urandom_range(0, 3)));
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    logic [7:0] e;
`ifdef IMM_RANGE_CHECK_EN
    e = 8'd255;
`else
    e = 8'd0;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int unsigned i = 0; i < 260; i++) send(32'h0000_0013, 32'h0000_0800, 2'd0);
    wait_drain();
    @(negedge clk);
    tests++;
    if (err_count !== e) begin
      fails++;
      $display("FAIL err_saturate: got %0d, expected %0d", err_count, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_imm = '0; in_immsrc = '0; out_ready = 1'b1;
    test_reset();
    test_i_latency();
    test_back_to_back();
    test_j_format();
    test_range();
    test_stall();
    test_reset_flush();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
